// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared fetch constants: PCSel encodings, nop, reset PC
package fetch_stage_pkg;

  // PCSel encodings, shared with the controller
  localparam logic [2:0] PC_SEL_PC4 = 3'd0;
  localparam logic [2:0] PC_SEL_BEQ = 3'd1;
  localparam logic [2:0] PC_SEL_JAL = 3'd2;
  localparam logic [2:0] PC_SEL_JR  = 3'd3;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

  // beq displacement: sign-extended 16-bit word offset turned into a byte offset
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_npc.sv
// rtl/fetch_stage_npc.sv - combinational next-PC selection from the D-stage instruction
module fetch_stage_npc
  import fetch_stage_pkg::*;
(
  input  logic [31:0] pc_f,
  input  logic [31:0] pc_d,
  input  logic [31:0] instr_d,
  input  logic [2:0]  pc_sel_d,
  input  logic        cmp_eq_d,
  input  logic [31:0] rs_data_d,
  output logic [31:0] npc
);

  logic [31:0] pc_f_plus4;
  logic [31:0] beq_target;

  assign pc_f_plus4 = pc_f + 32'd4;
  assign beq_target = pc_d + 32'd4 + branch_offset(instr_d[15:0]);

  // Redirect targets are relative to the instruction in D; sequential fetch continues from F
  always_comb begin
    npc = pc_f_plus4;
    case (pc_sel_d)
      PC_SEL_PC4: npc = pc_f_plus4;
      PC_SEL_BEQ: npc = cmp_eq_d ? beq_target : pc_f_plus4;
      PC_SEL_JAL: npc = {pc_d[31:28], instr_d[25:0], 2'b00};
      PC_SEL_JR:  npc = rs_data_d;
      default:    npc = pc_f_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - F stage: PC register, next-PC mux and IF/ID register (optional ALIGN_CHECK_EN)
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int          IM_DEPTH = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush_d,
  input  logic [2:0]  pc_sel_d,
  input  logic        cmp_eq_d,
  input  logic [31:0] rs_data_d,
  input  logic [31:0] im_rdata,
  output logic [31:0] im_addr,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        pc_err
);

  logic [31:0] pc_f;
  logic [31:0] npc;
  logic        fault;

  fetch_stage_npc u_npc (
    .pc_f      (pc_f),
    .pc_d      (pc_d),
    .instr_d   (instr_d),
    .pc_sel_d  (pc_sel_d),
    .cmp_eq_d  (cmp_eq_d),
    .rs_data_d (rs_data_d),
    .npc       (npc)
  );

  assign im_addr = pc_f;
  assign pc8_d   = pc_d + 32'd8;

`ifdef ALIGN_CHECK_EN
  localparam logic [31:0] IM_END = PC_RESET + 32'(4 * IM_DEPTH);

  logic bad_npc;
  logic err_q;

  assign bad_npc = (npc[1:0] != 2'b00) || (npc < PC_RESET) || (npc >= IM_END);

  // Sticky error: once a bad fetch address is seen, fetch freezes until reset
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (!stall && bad_npc) begin
      err_q <= 1'b1;
    end
  end

  assign fault  = bad_npc || err_q;
  assign pc_err = err_q;
`else
  assign fault  = 1'b0;
  assign pc_err = 1'b0;
`endif

  // PC and IF/ID update: stall freezes everything, so a waiting redirect is re-evaluated on release
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f    <= PC_RESET;
      instr_d <= NOP_INSTR;
      pc_d    <= PC_RESET;
    end else if (!stall) begin
      if (!fault) begin
        pc_f <= npc;
      end
      pc_d    <= pc_f;
      instr_d <= (flush_d || fault) ? NOP_INSTR : im_rdata;
    end
  end

endmodule
